// File: rtl/cpu_ctrl_fsm.sv
// Eight-phase instruction sequencer for the ZhenCPU datapath: walks fetch/execute
// phases and decodes memory, register-load and PC strobes from phase and opcode.
module cpu_ctrl_fsm #(
  parameter int OPCODE_W   = 3,
  parameter int NUM_PHASES = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  output logic                sel,
  output logic                rd,
  output logic                wr,
  output logic                ld_ir,
  output logic                ld_ac,
  output logic                ld_pc,
  output logic                inc_pc,
  output logic                data_e,
  output logic                halt,
  output logic [2:0]          phase
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_e;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  generate
    if (NUM_PHASES != 8) begin : g_bad_num_phases
      $error("cpu_ctrl_fsm: NUM_PHASES must be 8");
    end
    if (OPCODE_W < 3) begin : g_bad_opcode_w
      $error("cpu_ctrl_fsm: OPCODE_W must be at least 3");
    end
  endgenerate

  phase_e     phase_q, phase_d;
  logic       halted_q, halted_d;
  logic [2:0] op;
  logic       alu_op;

  // Only the low three opcode bits carry meaning; wider fields are truncated.
  always_comb begin
    op     = 3'(opcode);
    alu_op = (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  end

  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q;
    if (!halted_q) begin
      phase_d = phase_e'(3'(phase_q + 3'd1));
      if (phase_q == OP_ADDR && op == OP_HLT) begin
        halted_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  // Strobes follow the current phase directly so the datapath sees them in the same cycle.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    wr     = 1'b0;
    ld_ir  = 1'b0;
    ld_ac  = 1'b0;
    ld_pc  = 1'b0;
    inc_pc = 1'b0;
    data_e = 1'b0;
    halt   = halted_q;
    if (!halted_q) begin
      unique case (phase_q)
        INST_ADDR: begin
          sel = 1'b1;
        end
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = 1'b1;
        end
        OP_FETCH: begin
          rd = alu_op;
        end
        ALU_OP: begin
          rd     = alu_op;
          inc_pc = (op == OP_SKZ) && zero;
          ld_pc  = (op == OP_JMP);
          data_e = (op == OP_STO);
        end
        STORE: begin
          rd     = alu_op;
          ld_ac  = alu_op;
          ld_pc  = (op == OP_JMP);
          inc_pc = (op == OP_JMP);
          wr     = (op == OP_STO);
          data_e = (op == OP_STO);
        end
        default: begin
          sel = 1'b0;
        end
      endcase
    end
  end

  assign phase = phase_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_rd_wr_exclusive: assert (!(rd && wr));
      a_ld_pc_only_jmp:  assert (!ld_pc || op == OP_JMP);
    end
  end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Scoreboard bench for cpu_ctrl_fsm: directed instruction sequences push expected
// phase/strobe vectors; a monitor pops and compares them every cycle.
module tb_cpu_ctrl_fsm;

  logic       clk;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;
  logic       sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt;
  logic [2:0] phase;

  cpu_ctrl_fsm #(.OPCODE_W(3), .NUM_PHASES(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .opcode (opcode),
    .zero   (zero),
    .sel    (sel),
    .rd     (rd),
    .wr     (wr),
    .ld_ir  (ld_ir),
    .ld_ac  (ld_ac),
    .ld_pc  (ld_pc),
    .inc_pc (inc_pc),
    .data_e (data_e),
    .halt   (halt),
    .phase  (phase)
  );

  // Strobe vector order: {sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt}
  localparam logic [8:0] SEL  = 9'h100;
  localparam logic [8:0] RD   = 9'h080;
  localparam logic [8:0] WR   = 9'h040;
  localparam logic [8:0] LDIR = 9'h020;
  localparam logic [8:0] LDAC = 9'h010;
  localparam logic [8:0] LDPC = 9'h008;
  localparam logic [8:0] INC  = 9'h004;
  localparam logic [8:0] DE   = 9'h002;
  localparam logic [8:0] HLT  = 9'h001;
  localparam logic [8:0] NONE = 9'h000;

  typedef struct {
    string      name;
    logic [2:0] phase;
    logic [8:0] outs;
  } exp_t;

  exp_t       sb_q[$];
  logic [8:0] fetch_tbl [5];
  int         assertions = 0;
  int         failures   = 0;
  int         cyc        = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic applyStimulus(input logic r, input logic [2:0] op, input logic z,
                               input bit chk, input logic [2:0] ph,
                               input logic [8:0] ex, input string nm);
    exp_t e;
    rst    = r;
    opcode = op;
    zero   = z;
    if (chk) begin
      e.name  = nm;
      e.phase = ph;
      e.outs  = ex;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input exp_t e);
    logic [8:0] got;
    got = {sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt};
    assertions++;
    if (phase !== e.phase) begin
      failures++;
      $display("[TB] FAIL %s_phase cyc=%0d got %0d want %0d", e.name, cyc, phase, e.phase);
    end
    assertions++;
    if (got !== e.outs) begin
      failures++;
      $display("[TB] FAIL %s_strobes phase=%0d cyc=%0d got %b want %b",
               e.name, e.phase, cyc, got, e.outs);
    end
  endtask

  task automatic runInstr(input logic [2:0] op, input logic z, input logic [8:0] t5,
                          input logic [8:0] t6, input logic [8:0] t7, input string nm);
    for (int p = 0; p < 5; p++) applyStimulus(1'b0, op, z, 1'b1, 3'(p), fetch_tbl[p], nm);
    applyStimulus(1'b0, op, z, 1'b1, 3'd5, t5, nm);
    applyStimulus(1'b0, op, z, 1'b1, 3'd6, t6, nm);
    applyStimulus(1'b0, op, z, 1'b1, 3'd7, t7, nm);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    fetch_tbl[0] = SEL;
    fetch_tbl[1] = SEL | RD;
    fetch_tbl[2] = SEL | RD | LDIR;
    fetch_tbl[3] = SEL | RD | LDIR;
    fetch_tbl[4] = INC;

    // Reset held two cycles; only the second is checkable.
    applyStimulus(1'b1, 3'd2, 1'b0, 1'b0, 3'd0, NONE, "reset");
    applyStimulus(1'b1, 3'd2, 1'b0, 1'b1, 3'd0, SEL, "reset");

    runInstr(3'd2, 1'b0, RD, RD, RD | LDAC, "add");
    runInstr(3'd1, 1'b1, NONE, INC, NONE, "skz_z1");
    runInstr(3'd1, 1'b0, NONE, NONE, NONE, "skz_z0");
    runInstr(3'd6, 1'b1, NONE, DE, WR | DE, "sto");
    runInstr(3'd7, 1'b0, NONE, LDPC, LDPC | INC, "jmp");
    runInstr(3'd5, 1'b1, RD, RD, RD | LDAC, "lda");
    runInstr(3'd3, 1'b0, RD, RD, RD | LDAC, "and");
    runInstr(3'd4, 1'b1, RD, RD, RD | LDAC, "xor");

    // Halt: PC still increments in OP_ADDR, then everything freezes.
    for (int p = 0; p < 5; p++) applyStimulus(1'b0, 3'd0, 1'b0, 1'b1, 3'(p), fetch_tbl[p], "hlt");
    for (int i = 0; i < 22; i++) begin
      applyStimulus(1'b0, 3'(i), 1'(i), 1'b1, 3'd5, HLT, "halted");
    end
    applyStimulus(1'b1, 3'd6, 1'b0, 1'b1, 3'd5, HLT, "halted_rst");
    applyStimulus(1'b0, 3'd6, 1'b0, 1'b1, 3'd0, SEL, "unhalt");

    // Reset during STO's ALU_OP must suppress the STORE write.
    for (int p = 1; p < 5; p++) applyStimulus(1'b0, 3'd6, 1'b0, 1'b1, 3'(p), fetch_tbl[p], "sto_mid");
    applyStimulus(1'b0, 3'd6, 1'b0, 1'b1, 3'd5, NONE, "sto_mid");
    applyStimulus(1'b1, 3'd6, 1'b0, 1'b1, 3'd6, DE, "sto_mid_rst");
    runInstr(3'd6, 1'b0, NONE, DE, WR | DE, "sto_after_rst");

    repeat (3) @(posedge clk);
    assertions++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain got %0d pending want 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
